comparador_serial_der_izq: RTL and testbench

- Bit-serial, sequential version of the right-to-left iterative comparison cell chain. It computes the same Z function one bit per clock, so a single cell and a state register replace the N cascaded cells.
- It sits directly upstream of the result/display stage. It captures an N-bit operand pair on a start pulse and walks the bits LSB→MSB, carrying the inter-cell signal in a flip-flop.
- It presents Z_out with a one-cycle done pulse.

---
 rtl/comparador_serial_der_izq_if.sv | 16 +
 rtl/comparador_serial_der_izq.sv | 84 ++++++++
 tb/tb_comparador_serial_der_izq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/comparador_serial_der_izq_if.sv
// Request/result bundle for the bit-serial comparator: operands and seed in,
// busy/done/result out.
interface comparador_serial_der_izq_if #(
  parameter int N = 3
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         P;
  logic         busy;
  logic         done;
  logic         Z_out;

  modport master (output start, A, B, P, input busy, done, Z_out);
  modport slave  (input start, A, B, P, output busy, done, Z_out);
endinterface

// File: rtl/comparador_serial_der_izq.sv
// Bit-serial right-to-left comparator: one comparison cell walks the captured
// operands LSB to MSB, so the most significant differing bit decides Z.
module comparador_serial_der_izq #(
  parameter int N  = 3,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input logic                       clk,
  input logic                       reset,
  comparador_serial_der_izq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state_reg, state_next;
  logic [N-1:0]    shift_a_reg, shift_a_next;
  logic [N-1:0]    shift_b_reg, shift_b_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            s_reg, s_next;
  logic            z_reg, z_next;
  logic            cell_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_a_reg <= '0;
      shift_b_reg <= '0;
      cnt_reg     <= '0;
      s_reg       <= 1'b0;
      z_reg       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_a_reg <= shift_a_next;
      shift_b_reg <= shift_b_next;
      cnt_reg     <= cnt_next;
      s_reg       <= s_next;
      z_reg       <= z_next;
    end
  end

  // A differing bit pair overrides the carried signal; equal bits pass it on.
  assign cell_s = (shift_a_reg[0] != shift_b_reg[0]) ? shift_a_reg[0] : s_reg;

  always_comb begin
    state_next   = state_reg;
    shift_a_next = shift_a_reg;
    shift_b_next = shift_b_reg;
    cnt_next     = cnt_reg;
    s_next       = s_reg;
    z_next       = z_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          shift_a_next = bus.A;
          shift_b_next = bus.B;
          s_next       = bus.P;
          cnt_next     = '0;
          state_next   = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        s_next       = cell_s;
        shift_a_next = shift_a_reg >> 1;
        shift_b_next = shift_b_reg >> 1;
        // Counter holds on the last bit instead of wrapping past N-1.
        if (cnt_reg == LAST) begin
          z_next     = cell_s;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy  = (state_reg == SHIFT);
  assign bus.done  = (state_reg == DONE);
  assign bus.Z_out = z_reg;

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Self-checking bench for the serial comparator at N=3, N=1 and N=8, checked
// cycle by cycle against an arithmetic reference of the comparison function.
module tb_comparador_serial_der_izq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  comparador_serial_der_izq_if #(.N(3)) if3 ();
  comparador_serial_der_izq_if #(.N(1)) if1 ();
  comparador_serial_der_izq_if #(.N(8)) if8 ();

  comparador_serial_der_izq #(.N(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));
  comparador_serial_der_izq #(.N(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  comparador_serial_der_izq #(.N(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: unsigned compare of the low n bits, seed decides on equality.
  function automatic logic ref_z(input int n, input logic [15:0] a, input logic [15:0] b,
                                 input logic p);
    logic [16:0] mask;
    logic [16:0] am;
    logic [16:0] bm;
    mask = (17'h1 << n) - 17'h1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    if (am > bm) return 1'b1;
    if (am == bm) return p;
    return 1'b0;
  endfunction

  function automatic int width_of(input int w);
    case (w)
      0:       return 3;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  task automatic drive(input int w, input logic st, input logic [15:0] a,
                       input logic [15:0] b, input logic p);
    case (w)
      0: begin if3.start = st; if3.A = a[2:0]; if3.B = b[2:0]; if3.P = p; end
      1: begin if1.start = st; if1.A = a[0:0]; if1.B = b[0:0]; if1.P = p; end
      default: begin if8.start = st; if8.A = a[7:0]; if8.B = b[7:0]; if8.P = p; end
    endcase
  endtask

  task automatic sample(input int w, output logic bsy, output logic dn, output logic z);
    case (w)
      0: begin bsy = if3.busy; dn = if3.done; z = if3.Z_out; end
      1: begin bsy = if1.busy; dn = if1.done; z = if1.Z_out; end
      default: begin bsy = if8.busy; dn = if8.done; z = if8.Z_out; end
    endcase
  endtask

  task automatic drive_junk(input int w, input logic st);
    drive(w, st, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // One comparison: operands are scrambled after capture; optional start poke mid-SHIFT.
  task automatic run_cmp(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic p, input bit poke);
    int   n;
    logic bsy, dn, z, exp_z;
    n     = width_of(w);
    exp_z = ref_z(n, a, b, p);
    @(negedge clk);
    drive(w, 1'b1, a, b, p);
    @(posedge clk);
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      if (k == 2 && poke && n >= 2) drive_junk(w, 1'b1);
      else drive_junk(w, 1'b0);
      sample(w, bsy, dn, z);
      check($sformatf("busy_n%0d_a%0h_b%0h_k%0d", n, a, b, k), 16'(bsy), 16'(k <= n));
      check($sformatf("done_n%0d_a%0h_b%0h_k%0d", n, a, b, k), 16'(dn), 16'(k == n + 1));
      if (k == n + 1)
        check($sformatf("z_n%0d_a%0h_b%0h_p%0d", n, a, b, p), 16'(z), 16'(exp_z));
    end
    @(negedge clk);
    sample(w, bsy, dn, z);
    check($sformatf("idle_busy_n%0d", n), 16'(bsy), 16'(0));
    check($sformatf("idle_done_n%0d", n), 16'(dn), 16'(0));
    check($sformatf("z_hold_n%0d", n), 16'(z), 16'(exp_z));
  endtask

  initial begin
    logic bsy, dn, z;
    reset = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int w = 0; w < 3; w++) begin
      sample(w, bsy, dn, z);
      check($sformatf("rst_busy_w%0d", w), 16'(bsy), 16'(0));
      check($sformatf("rst_done_w%0d", w), 16'(dn), 16'(0));
      check($sformatf("rst_z_w%0d", w), 16'(z), 16'(0));
    end

    // Directed cases, with a start poke during SHIFT that must be ignored.
    run_cmp(0, 16'd5, 16'd3, 1'b0, 1'b1);
    run_cmp(0, 16'd3, 16'd5, 1'b1, 1'b1);
    run_cmp(0, 16'd6, 16'd6, 1'b1, 1'b1);
    run_cmp(0, 16'd6, 16'd6, 1'b0, 1'b1);
    run_cmp(0, 16'd4, 16'd3, 1'b0, 1'b1);
    run_cmp(0, 16'd1, 16'd2, 1'b0, 1'b1);

    // start held high: back-to-back (5,3) then (3,5), done every 4 cycles.
    @(negedge clk);
    drive(0, 1'b1, 16'd5, 16'd3, 1'b0);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) drive(0, 1'b1, 16'd3, 16'd5, 1'b0);
      if (k == 8) drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
      sample(0, bsy, dn, z);
      check($sformatf("b2b_busy_k%0d", k), 16'(bsy), 16'((k % 4) != 0));
      check($sformatf("b2b_done_k%0d", k), 16'(dn), 16'((k % 4) == 0));
      if (k == 4) check("b2b_z_first", 16'(z), 16'(1));
      if (k == 8) check("b2b_z_second", 16'(z), 16'(0));
    end
    @(negedge clk);
    sample(0, bsy, dn, z);
    check("b2b_tail_busy", 16'(bsy), 16'(0));
    check("b2b_tail_done", 16'(dn), 16'(0));

    // Reset mid-SHIFT, with start asserted alongside reset.
    run_cmp(0, 16'd5, 16'd3, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'd5, 16'd3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_junk(0, 1'b0);
    sample(0, bsy, dn, z);
    check("rstmid_busy_c1", 16'(bsy), 16'(1));
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b1, 16'd6, 16'd1, 1'b1);
    sample(0, bsy, dn, z);
    check("rstmid_busy_c2", 16'(bsy), 16'(1));
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
    sample(0, bsy, dn, z);
    check("rstmid_busy_after", 16'(bsy), 16'(0));
    check("rstmid_done_after", 16'(dn), 16'(0));
    check("rstmid_z_after", 16'(z), 16'(0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      sample(0, bsy, dn, z);
      check($sformatf("rstmid_quiet_busy_%0d", k), 16'(bsy), 16'(0));
      check($sformatf("rstmid_quiet_done_%0d", k), 16'(dn), 16'(0));
    end
    run_cmp(0, 16'd4, 16'd3, 1'b0, 1'b0);

    // Exhaustive N=3 and N=1, random N=8.
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int p = 0; p < 2; p++)
          run_cmp(0, 16'(a), 16'(b), 1'(p), 1'b0);
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int p = 0; p < 2; p++)
          run_cmp(1, 16'(a), 16'(b), 1'(p), 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom_range(0, 255));
      rb = (i % 5 == 0) ? ra : 16'($urandom_range(0, 255));
      run_cmp(2, ra, rb, 1'($urandom), 1'(i % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
